// File: rtl/scrisc_branch_pkg.sv
// Shared encodings for the branch resolve unit: condition-code fields and the
// 2-bit direction-predictor counter states.
package scrisc_branch_pkg;

    // Condition codes; bit 1 inverts the base test, bit 2 selects a relational test.
    localparam logic [2:0] COND_EQ  = 3'b000;
    localparam logic [2:0] COND_NE  = 3'b010;
    localparam logic [2:0] COND_LT  = 3'b100;
    localparam logic [2:0] COND_LTU = 3'b101;
    localparam logic [2:0] COND_GE  = 3'b110;
    localparam logic [2:0] COND_GEU = 3'b111;

    localparam int unsigned COND_UNS_BIT = 0;
    localparam int unsigned COND_INV_BIT = 1;
    localparam int unsigned COND_REL_BIT = 2;

    typedef enum logic [1:0] {
        CntSnt = 2'b00,
        CntWnt = 2'b01,
        CntWt  = 2'b10,
        CntSt  = 2'b11
    } bht_cnt_e;

    function automatic bht_cnt_e bht_next(input bht_cnt_e cur, input logic taken);
        bht_cnt_e nxt;
        case (cur)
            CntSnt:  nxt = taken ? CntWnt : CntSnt;
            CntWnt:  nxt = taken ? CntWt  : CntSnt;
            CntWt:   nxt = taken ? CntSt  : CntWnt;
            default: nxt = taken ? CntSt  : CntWt;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/branch_history_table.sv
// Table of 2-bit saturating direction counters: one combinational read port and
// one read-modify-write update port. Reads see the pre-update value.
import scrisc_branch_pkg::*;

module branch_history_table #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [IDX_W-1:0] rd_idx,
    output bht_cnt_e         rd_cnt,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic             wr_taken
);

    bht_cnt_e cnt_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                cnt_q[i] <= CntWnt;
            end
        end else if (wr_en) begin
            cnt_q[wr_idx] <= bht_next(cnt_q[wr_idx], wr_taken);
        end
    end

    assign rd_cnt = cnt_q[rd_idx];

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch resolve unit: combinational compare of two operands, a one-deep
// result register with valid/ready handshake, and a BHT-based direction predictor.
import scrisc_branch_pkg::*;

module branch_resolve_unit #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned PC_W      = 16,
    parameter int unsigned BHT_DEPTH = 16,
    parameter int unsigned CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             lk_valid,
    input  logic [PC_W-1:0]  lk_pc,
    output logic             pred_valid,
    output logic             pred_taken,
    input  logic             rs_valid,
    output logic             rs_ready,
    input  logic [WIDTH-1:0] rs_a,
    input  logic [WIDTH-1:0] rs_b,
    input  logic [2:0]       rs_cond,
    input  logic [PC_W-1:0]  rs_pc,
    input  logic             rs_pred_taken,
    input  logic             flush,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_taken,
    output logic             res_mispredict,
    output logic [CNT_W-1:0] misp_count
);

    localparam int unsigned IDX_W = $clog2(BHT_DEPTH);

    logic [WIDTH:0] diff;
    logic           zero, ltu, ovf, lt_s, base, taken, fire;

    logic             res_valid_q, res_valid_d;
    logic             res_taken_q, res_taken_d;
    logic             res_misp_q, res_misp_d;
    logic [CNT_W-1:0] misp_q, misp_d;
    logic             pred_valid_q, pred_taken_q;
    bht_cnt_e         rd_cnt;

    // Compare datapath: one subtract yields equality, borrow and signed less-than.
    assign diff = {1'b0, rs_a} - {1'b0, rs_b};
    assign zero = (diff[WIDTH-1:0] == '0);
    assign ltu  = diff[WIDTH];
    assign ovf  = (rs_a[WIDTH-1] != rs_b[WIDTH-1]) && (diff[WIDTH-1] != rs_a[WIDTH-1]);
    assign lt_s = diff[WIDTH-1] ^ ovf;

    always_comb begin
        base = zero;
        if (rs_cond[COND_REL_BIT]) begin
            base = rs_cond[COND_UNS_BIT] ? ltu : lt_s;
        end
        taken = base ^ rs_cond[COND_INV_BIT];
    end

    assign rs_ready = !res_valid_q || res_ready;
    assign fire     = rs_valid && rs_ready && !flush;

    always_comb begin
        res_valid_d = res_valid_q;
        res_taken_d = res_taken_q;
        res_misp_d  = res_misp_q;
        misp_d      = misp_q;
        if (flush) begin
            res_valid_d = 1'b0;
        end else if (fire) begin
            res_valid_d = 1'b1;
            res_taken_d = taken;
            res_misp_d  = taken ^ rs_pred_taken;
            if ((taken != rs_pred_taken) && (misp_q != '1)) begin
                misp_d = misp_q + CNT_W'(1);
            end
        end else if (res_ready) begin
            res_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_q  <= 1'b0;
            res_taken_q  <= 1'b0;
            res_misp_q   <= 1'b0;
            misp_q       <= '0;
            pred_valid_q <= 1'b0;
            pred_taken_q <= 1'b0;
        end else begin
            res_valid_q  <= res_valid_d;
            res_taken_q  <= res_taken_d;
            res_misp_q   <= res_misp_d;
            misp_q       <= misp_d;
            pred_valid_q <= lk_valid;
            if (lk_valid) begin
                pred_taken_q <= rd_cnt[1];
            end
        end
    end

    branch_history_table #(
        .DEPTH (BHT_DEPTH),
        .IDX_W (IDX_W)
    ) u_bht (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_idx   (lk_pc[IDX_W+1:2]),
        .rd_cnt   (rd_cnt),
        .wr_en    (fire),
        .wr_idx   (rs_pc[IDX_W+1:2]),
        .wr_taken (taken)
    );

    // PC bits outside the table index and the counter's low bit carry no meaning here.
    logic unused_bits;
    assign unused_bits = ^{lk_pc[PC_W-1:IDX_W+2], lk_pc[1:0],
                           rs_pc[PC_W-1:IDX_W+2], rs_pc[1:0], rd_cnt[0]};

    assign res_valid      = res_valid_q;
    assign res_taken      = res_taken_q;
    assign res_mispredict = res_misp_q;
    assign misp_count     = misp_q;
    assign pred_valid     = pred_valid_q;
    assign pred_taken     = pred_taken_q;

endmodule

// File: doc/branch_resolve_unit.md
BRANCH_RESOLVE_UNIT -- requirements
Module: branch_resolve_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width in bits (>=4).
REQ-002 SHALL have parameter PC_W, default 16, program-counter width.
REQ-003 SHALL have parameter BHT_DEPTH, default 16, prediction table entries; power of two, >=2.
REQ-004 SHALL have parameter CNT_W, default 8, mispredict statistics counter width.
REQ-005 SHALL have one clock and an asynchronous active-low reset, named as follows.
clk  in  1  single clock, all state on rising edge.
rst_n  in  1  asynchronous active-low reset.
lk_valid  in  1  prediction lookup request.
lk_pc  in  PC_W  lookup PC.
pred_valid  out  1  lookup result valid, one cycle after lk_valid.
pred_taken  out  1  predicted direction.
rs_valid  in  1  resolve request valid.
rs_ready  out  1  resolve request accepted when high with rs_valid.
rs_a, rs_b  in  WIDTH  compare operands.
rs_cond  in  3  condition code.
rs_pc  in  PC_W  branch PC.
rs_pred_taken  in  1  direction that was predicted.
flush  in  1  discard in-flight and incoming resolve.
res_valid  out  1  result valid.
res_ready  in  1  consumer accepts result.
res_taken  out  1  resolved direction.
res_mispredict  out  1  res_taken != captured rs_pred_taken.
misp_count  out  CNT_W  saturating mispredict count.

Function
REQ-006 SHALL decode rs_cond: 000/001 EQ, 010/011 NE, 100 LT signed, 110 GE signed, 101 LTU, 111 GEU; bit1 inverts the base test.
REQ-007 SHALL compute diff = rs_a - rs_b at WIDTH+1 bits; zero = (diff[WIDTH-1:0]==0); ltu = diff[WIDTH] (borrow).
REQ-008 SHALL compute signed lt = diff[WIDTH-1] XOR ovf, ovf = (a_msb != b_msb) AND (diff[WIDTH-1] != a_msb).
REQ-009 SHALL define fire = rs_valid AND rs_ready AND NOT flush; rs_ready = NOT res_valid OR res_ready.
REQ-010 SHALL on fire register res_taken, res_mispredict and set res_valid next cycle (latency 1).
REQ-011 SHALL clear res_valid when res_valid AND res_ready AND NOT fire; hold all res_* stable while res_valid AND NOT res_ready.
REQ-012 SHALL on flush clear res_valid next cycle, perform no table update and no count increment.
REQ-013 SHALL hold BHT_DEPTH 2-bit saturating counters (00 SNT, 01 WNT, 10 WT, 11 ST) indexed by pc[log2(BHT_DEPTH)+1:2].
REQ-014 SHALL on fire increment the indexed counter if taken, decrement if not, saturating at 11 and 00.
REQ-015 SHALL on lk_valid register pred_taken = counter[1] of the lk_pc entry and pulse pred_valid one cycle; lookup and update to the same entry in one cycle returns the pre-update value.
REQ-016 SHALL increment misp_count on fire with mispredict; hold at all-ones.

Reset
REQ-017 SHALL on rst_n low, asynchronously: res_valid=0, res_taken=0, res_mispredict=0, pred_valid=0, pred_taken=0, misp_count=0, all counters=01.
REQ-018 SHALL drop any in-flight result on reset; rs_ready=1 out of reset.

Structure
REQ-019 SHALL place condition-code constants and counter-state encodings in package scrisc_branch_pkg.
REQ-020 SHALL implement the counter table as sub-module branch_history_table (one read port, one write port).
REQ-021 SHALL keep the compare datapath combinational and in the top module.

Verification
REQ-022 SHALL cover: a=16'h8000, b=16'h0001, cond 100 -> res_taken=1; same with cond 101 -> res_taken=0.
REQ-023 SHALL cover: a=16'h7FFF, b=16'h8000, cond 110 -> res_taken=1; cond 111 -> res_taken=0; a=b=16'h1234 cond 000 -> 1.
REQ-024 SHALL cover: three taken resolves at pc=16'h0004 from reset -> counter 01,10,11,11; lookup pc=16'h0004 -> pred_taken=1.
REQ-025 SHALL cover: res_ready=0 with res_valid=1 for 3 cycles -> rs_ready=0, res_* unchanged, no table update.
REQ-026 SHALL cover: flush with rs_valid same cycle -> res_valid=0 next cycle, counter and misp_count unchanged.
REQ-027 SHALL cover: rst_n low mid-operation with res_valid=1 and misp_count=5 -> immediately res_valid=0, misp_count=0, lookup returns pred_taken=0.
